// File: rtl/nco_pkg.sv
// Shared definitions for the NCO phase generator: config addresses,
// FSM state encoding and the default phase width.
package nco_pkg;

  localparam int PHASE_W_DEF = 32;

  localparam logic [2:0] ADDR_FTW    = 3'd0;
  localparam logic [2:0] ADDR_POFF   = 3'd1;
  localparam logic [2:0] ADDR_DIV    = 3'd2;
  localparam logic [2:0] ADDR_BLEN   = 3'd3;
  localparam logic [2:0] ADDR_STEP   = 3'd4;
  localparam logic [2:0] ADDR_COMMIT = 3'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/nco_phase_gen.sv
// Programmable phase generator feeding sin_linear. A divider sets the
// sample rate, an accumulator builds the wrapping phase, and FTW itself
// can be ramped by a signed STEP to produce a linear chirp. Runs are
// either fixed-length bursts or continuous until stopped.
module nco_phase_gen
  import nco_pkg::*;
#(
  parameter int PHASE_W = PHASE_W_DEF,
  parameter int DIV_W   = 16,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_we,
  input  logic [2:0]         cfg_addr,
  input  logic [PHASE_W-1:0] cfg_wdata,
  input  logic               start,
  input  logic               stop,
  output logic               busy,
  output logic               done,
  output logic               valid_o,
  output logic [PHASE_W-1:0] phase_o,
  output logic [CNT_W-1:0]   sample_idx_o
);

  state_t state;
  state_t state_nxt;

  logic [PHASE_W-1:0] ftw_sh;
  logic [PHASE_W-1:0] poff_sh;
  logic [DIV_W-1:0]   div_sh;
  logic [CNT_W-1:0]   blen_sh;
  logic [PHASE_W-1:0] step_sh;

  logic [PHASE_W-1:0] ftw_a;
  logic [PHASE_W-1:0] poff_a;
  logic [DIV_W-1:0]   div_a;
  logic [CNT_W-1:0]   blen_a;
  logic [PHASE_W-1:0] step_a;

  logic [PHASE_W-1:0] acc;
  logic [DIV_W-1:0]   div_cnt;
  logic [CNT_W-1:0]   idx;

  logic tick;
  logic load;
  logic last;
  logic commit;
  logic done_nxt;

  // Burst ends on the tick that emits index BLEN-1; BLEN of zero never ends.
  assign last = (blen_a != '0) && (idx == blen_a - CNT_W'(1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; stop always wins over start and over burst completion.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start && !stop) state_nxt = RUN;
      RUN: begin
        if (stop) begin
          state_nxt = IDLE;
        end else if ((div_cnt == '0) && last) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Control strobes derived from the current state; a stopped tick is dropped.
  always_comb begin
    tick     = 1'b0;
    load     = 1'b0;
    commit   = 1'b0;
    done_nxt = 1'b0;
    busy     = 1'b0;
    case (state)
      IDLE: load = start && !stop;
      RUN: begin
        busy   = 1'b1;
        tick   = (div_cnt == '0) && !stop;
        commit = cfg_we && (cfg_addr == ADDR_COMMIT);
      end
      DONE:    done_nxt = !stop;
      default: ;
    endcase
  end

  // Shadow registers take every config write; COMMIT and 6-7 hold no data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ftw_sh  <= '0;
      poff_sh <= '0;
      div_sh  <= '0;
      blen_sh <= '0;
      step_sh <= '0;
    end else if (cfg_we) begin
      case (cfg_addr)
        ADDR_FTW:  ftw_sh  <= cfg_wdata;
        ADDR_POFF: poff_sh <= cfg_wdata;
        ADDR_DIV:  div_sh  <= cfg_wdata[DIV_W-1:0];
        ADDR_BLEN: blen_sh <= cfg_wdata[CNT_W-1:0];
        ADDR_STEP: step_sh <= cfg_wdata;
        default: ;
      endcase
    end
  end

  // Active registers, divider, accumulator and registered sample outputs.
  // A COMMIT lands on the active set immediately; since FTW/POFF/STEP are
  // only consumed on ticks, the next tick is the first to see them, and a
  // commit coinciding with a tick overrides that tick's FTW ramp update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ftw_a        <= '0;
      poff_a       <= '0;
      div_a        <= '0;
      blen_a       <= '0;
      step_a       <= '0;
      acc          <= '0;
      div_cnt      <= '0;
      idx          <= '0;
      valid_o      <= 1'b0;
      done         <= 1'b0;
      phase_o      <= '0;
      sample_idx_o <= '0;
    end else begin
      valid_o <= tick;
      done    <= done_nxt;
      if (load) begin
        ftw_a   <= ftw_sh;
        poff_a  <= poff_sh;
        div_a   <= div_sh;
        blen_a  <= blen_sh;
        step_a  <= step_sh;
        acc     <= '0;
        div_cnt <= '0;
        idx     <= '0;
      end else if (tick) begin
        phase_o      <= acc + poff_a;
        sample_idx_o <= idx;
        acc          <= acc + ftw_a;
        ftw_a        <= ftw_a + step_a;
        idx          <= idx + CNT_W'(1);
        div_cnt      <= div_a;
      end else if (state == RUN) begin
        div_cnt <= div_cnt - DIV_W'(1);
      end
      if (commit) begin
        ftw_a  <= ftw_sh;
        poff_a <= poff_sh;
        step_a <= step_sh;
      end
    end
  end

endmodule

// File: tb/tb_nco_phase_gen.sv
// Directed bench for nco_phase_gen: bursts, rate divider, wrap, chirps,
// live commit, stop, async reset and simultaneous start/stop.
module tb_nco_phase_gen;
  import nco_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        cfg_we;
  logic [2:0]  cfg_addr;
  logic [31:0] cfg_wdata;
  logic        start;
  logic        stop;
  logic        busy;
  logic        done;
  logic        valid_o;
  logic [31:0] phase_o;
  logic [15:0] sample_idx_o;

  int errCount;
  int checkCount;

  logic [31:0] capPhase [16];
  int          capIdx   [16];
  int          capCyc   [16];
  int          nValid;
  int          doneCyc;
  int          doneCount;

  nco_phase_gen #(.PHASE_W(32), .DIV_W(16), .CNT_W(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg_we       (cfg_we),
    .cfg_addr     (cfg_addr),
    .cfg_wdata    (cfg_wdata),
    .start        (start),
    .stop         (stop),
    .busy         (busy),
    .done         (done),
    .valid_o      (valid_o),
    .phase_o      (phase_o),
    .sample_idx_o (sample_idx_o)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic cfgWrite(input logic [2:0] addr, input logic [31:0] data);
    cfg_we    = 1'b1;
    cfg_addr  = addr;
    cfg_wdata = data;
    @(posedge clk); #1;
    cfg_we    = 1'b0;
  endtask

  task automatic setupRun(input logic [31:0] ftw, input logic [31:0] poff,
                          input logic [31:0] dv, input logic [31:0] blen,
                          input logic [31:0] step);
    cfgWrite(ADDR_FTW, ftw);
    cfgWrite(ADDR_POFF, poff);
    cfgWrite(ADDR_DIV, dv);
    cfgWrite(ADDR_BLEN, blen);
    cfgWrite(ADDR_STEP, step);
  endtask

  task automatic applyStimulus(input logic st, input logic sp);
    start = st;
    stop  = sp;
    @(posedge clk); #1;
    start = 1'b0;
    stop  = 1'b0;
  endtask

  // Record every valid sample and done pulse for a bounded number of cycles.
  task automatic captureRun(input int cycles);
    nValid    = 0;
    doneCyc   = -1;
    doneCount = 0;
    for (int c = 1; c <= cycles; c++) begin
      @(posedge clk); #1;
      if (valid_o) begin
        if (nValid < 16) begin
          capPhase[nValid] = phase_o;
          capIdx[nValid]   = int'(sample_idx_o);
          capCyc[nValid]   = c;
        end
        nValid++;
      end
      if (done) begin
        doneCount++;
        if (doneCyc < 0) doneCyc = c;
      end
    end
  endtask

  logic [31:0] expPh [8];
  logic [31:0] diff;

  initial begin
    errCount   = 0;
    checkCount = 0;
    rst_n      = 1'b0;
    cfg_we     = 1'b0;
    cfg_addr   = 3'd0;
    cfg_wdata  = 32'h0;
    start      = 1'b0;
    stop       = 1'b0;
    #12;
    checkOutput("reset_busy", {31'b0, busy}, 32'h0);
    checkOutput("reset_valid", {31'b0, valid_o}, 32'h0);
    checkOutput("reset_done", {31'b0, done}, 32'h0);
    checkOutput("reset_phase", phase_o, 32'h0);
    checkOutput("reset_idx", {16'b0, sample_idx_o}, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] basic burst");
    setupRun(32'h0100_0000, 32'h0, 32'd0, 32'd4, 32'h0);
    applyStimulus(1'b1, 1'b0);
    checkOutput("burst_busy", {31'b0, busy}, 32'h1);
    checkOutput("burst_valid0", {31'b0, valid_o}, 32'h0);
    captureRun(6);
    checkOutput("burst_count", nValid, 32'd4);
    expPh[0] = 32'h0000_0000; expPh[1] = 32'h0100_0000;
    expPh[2] = 32'h0200_0000; expPh[3] = 32'h0300_0000;
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("burst_phase%0d", i), capPhase[i], expPh[i]);
      checkOutput($sformatf("burst_idx%0d", i), capIdx[i], i);
      checkOutput($sformatf("burst_cyc%0d", i), capCyc[i], i + 1);
    end
    checkOutput("burst_done_cyc", doneCyc, 32'd5);
    checkOutput("burst_done_cnt", doneCount, 32'd1);
    checkOutput("burst_busy_end", {31'b0, busy}, 32'h0);

    $display("[TB] rate divider");
    setupRun(32'h10, 32'h0, 32'd2, 32'd3, 32'h0);
    applyStimulus(1'b1, 1'b0);
    captureRun(10);
    checkOutput("div_count", nValid, 32'd3);
    expPh[0] = 32'h0; expPh[1] = 32'h10; expPh[2] = 32'h20;
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("div_phase%0d", i), capPhase[i], expPh[i]);
      checkOutput($sformatf("div_cyc%0d", i), capCyc[i], 1 + 3 * i);
    end
    checkOutput("div_done_cyc", doneCyc, 32'd8);

    $display("[TB] wrap with offset");
    setupRun(32'h8000_0000, 32'h4000_0000, 32'd0, 32'd3, 32'h0);
    applyStimulus(1'b1, 1'b0);
    captureRun(5);
    checkOutput("wrap_count", nValid, 32'd3);
    expPh[0] = 32'h4000_0000; expPh[1] = 32'hC000_0000; expPh[2] = 32'h4000_0000;
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("wrap_phase%0d", i), capPhase[i], expPh[i]);
    end

    $display("[TB] chirp up");
    setupRun(32'h0, 32'h0, 32'd0, 32'd5, 32'h1);
    applyStimulus(1'b1, 1'b0);
    captureRun(7);
    checkOutput("chirp_count", nValid, 32'd5);
    expPh[0] = 32'd0; expPh[1] = 32'd0; expPh[2] = 32'd1; expPh[3] = 32'd3; expPh[4] = 32'd6;
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("chirp_phase%0d", i), capPhase[i], expPh[i]);
    end

    $display("[TB] chirp down");
    setupRun(32'h2, 32'h0, 32'd0, 32'd4, 32'hFFFF_FFFF);
    applyStimulus(1'b1, 1'b0);
    captureRun(6);
    checkOutput("chirpdn_count", nValid, 32'd4);
    expPh[0] = 32'd0; expPh[1] = 32'd2; expPh[2] = 32'd3; expPh[3] = 32'd3;
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("chirpdn_phase%0d", i), capPhase[i], expPh[i]);
    end

    $display("[TB] commit and stop, continuous");
    setupRun(32'h1, 32'h0, 32'd3, 32'd0, 32'h0);
    applyStimulus(1'b1, 1'b0);
    captureRun(10);
    checkOutput("cont_count", nValid, 32'd3);
    expPh[0] = 32'd0; expPh[1] = 32'd1; expPh[2] = 32'd2;
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("cont_phase%0d", i), capPhase[i], expPh[i]);
    end
    checkOutput("cont_no_done", doneCount, 32'd0);
    cfgWrite(ADDR_FTW, 32'h100);
    cfgWrite(ADDR_COMMIT, 32'h0);
    captureRun(8);
    checkOutput("commit_count", nValid, 32'd2);
    diff = capPhase[1] - capPhase[0];
    checkOutput("commit_incr", diff, 32'h100);
    applyStimulus(1'b0, 1'b1);
    checkOutput("stop_valid", {31'b0, valid_o}, 32'h0);
    checkOutput("stop_busy", {31'b0, busy}, 32'h0);
    captureRun(8);
    checkOutput("stop_no_valid", nValid, 32'd0);
    checkOutput("stop_no_done", doneCount, 32'd0);

    $display("[TB] async reset mid-run");
    setupRun(32'h5, 32'h7, 32'd0, 32'd0, 32'h0);
    applyStimulus(1'b1, 1'b0);
    captureRun(3);
    checkOutput("pre_reset_valid", {31'b0, valid_o}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_busy", {31'b0, busy}, 32'h0);
    checkOutput("rst_valid", {31'b0, valid_o}, 32'h0);
    checkOutput("rst_done", {31'b0, done}, 32'h0);
    checkOutput("rst_phase", phase_o, 32'h0);
    checkOutput("rst_idx", {16'b0, sample_idx_o}, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    captureRun(3);
    checkOutput("post_rst_valid", nValid, 32'd0);
    checkOutput("post_rst_done", doneCount, 32'd0);

    $display("[TB] start and stop together");
    setupRun(32'h1, 32'h0, 32'd0, 32'd0, 32'h0);
    applyStimulus(1'b1, 1'b1);
    checkOutput("ss_busy", {31'b0, busy}, 32'h0);
    captureRun(5);
    checkOutput("ss_no_valid", nValid, 32'd0);
    checkOutput("ss_busy_end", {31'b0, busy}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
